// File: rtl/tlb_ctrl_pkg.sv
// rtl/tlb_ctrl_pkg.sv - shared geometry, state encodings and permission helper for tlb_ctrl
package tlb_ctrl_pkg;

  localparam int NUM_SETS       = 16;
  localparam int NUM_WAYS       = 4;
  localparam int SET_INDEX_BITS = 4;
  localparam int WAY_BITS       = 2;
  localparam int LRU_BITS       = 4;
  localparam int FLUSH_BITS     = $clog2(NUM_SETS * NUM_WAYS);
  localparam logic [LRU_BITS-1:0] LRU_MAX = '1;

  localparam int PERM_R = 0;
  localparam int PERM_W = 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WALK_REQ  = 3'd2;
  localparam logic [2:0] S_WALK_WAIT = 3'd3;
  localparam logic [2:0] S_REFILL    = 3'd4;
  localparam logic [2:0] S_AGE       = 3'd5;
  localparam logic [2:0] S_FLUSH     = 3'd6;

  typedef logic [19:0] vpn_t;

  function automatic logic perm_fault(input logic is_write, input logic [1:0] perms);
    return is_write ? ~perms[PERM_W] : ~perms[PERM_R];
  endfunction

endpackage

// File: rtl/tlb_victim_sel.sv
// rtl/tlb_victim_sel.sv - picks the refill way: lowest invalid way, else lowest age (lowest index on ties)
module tlb_victim_sel
  import tlb_ctrl_pkg::*;
(
  input  logic [NUM_WAYS-1:0]               valid,
  input  logic [NUM_WAYS-1:0][LRU_BITS-1:0] lru,
  output logic [WAY_BITS-1:0]               way
);

  logic                found;
  logic [LRU_BITS-1:0] best;

  always_comb begin
    way   = '0;
    found = 1'b0;
    best  = lru[0];
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!found && !valid[i]) begin
        way   = WAY_BITS'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int i = 1; i < NUM_WAYS; i++) begin
        if (lru[i] < best) begin
          best = lru[i];
          way  = WAY_BITS'(i);
        end
      end
    end
  end

endmodule

// File: rtl/tlb_ctrl.sv
// rtl/tlb_ctrl.sv - TLB sequencer: lookup, page walk, refill, LRU aging, flush and hit/miss counters
module tlb_ctrl
  import tlb_ctrl_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [31:0]                         req_vaddr,
  input  logic                                req_is_write,
  output logic                                resp_valid,
  output logic [31:0]                         resp_paddr,
  output logic                                resp_hit,
  output logic                                resp_fault,
  input  logic                                flush,
  output logic                                flush_busy,
  output logic                                ptw_req_valid,
  input  logic                                ptw_req_ready,
  output logic [19:0]                         ptw_req_vpn,
  input  logic                                ptw_resp_valid,
  input  logic [19:0]                         ptw_resp_ppn,
  input  logic [1:0]                          ptw_resp_perms,
  input  logic                                ptw_resp_fault,
  output logic [SET_INDEX_BITS-1:0]           st_rd_set_index,
  input  logic [NUM_WAYS-1:0]                 st_rd_valid,
  input  logic [NUM_WAYS-1:0][19:0]           st_rd_vpn,
  input  logic [NUM_WAYS-1:0][19:0]           st_rd_ppn,
  input  logic [NUM_WAYS-1:0][1:0]            st_rd_perms,
  input  logic [NUM_WAYS-1:0][LRU_BITS-1:0]   st_rd_lru_count,
  output logic                                st_wr_en,
  output logic [SET_INDEX_BITS-1:0]           st_wr_set_index,
  output logic [1:0]                          st_wr_way,
  output logic                                st_wr_valid,
  output logic [19:0]                         st_wr_vpn,
  output logic [19:0]                         st_wr_ppn,
  output logic [1:0]                          st_wr_perms,
  output logic [LRU_BITS-1:0]                 st_wr_lru_count,
  output logic                                st_lru_update_en,
  output logic [SET_INDEX_BITS-1:0]           st_lru_set_index,
  output logic [1:0]                          st_lru_way,
  output logic [LRU_BITS-1:0]                 st_lru_value,
  output logic [15:0]                         hit_count,
  output logic [15:0]                         miss_count
);

  logic [2:0]                        state;
  vpn_t                              req_vpn;
  logic [11:0]                       req_off;
  logic                              req_wr;
  logic [NUM_WAYS-1:0]               snap_valid;
  logic [NUM_WAYS-1:0][LRU_BITS-1:0] snap_lru;
  logic [WAY_BITS-1:0]               used_way, age_idx, hit_way, victim;
  logic [FLUSH_BITS-1:0]             flush_idx;
  vpn_t                              walk_ppn;
  logic [1:0]                        walk_perms;
  logic                              hit, age_dec, in_flush, in_lookup;
  logic [SET_INDEX_BITS-1:0]         set_idx;

  assign set_idx   = req_vpn[SET_INDEX_BITS-1:0];
  assign in_flush  = (state == S_FLUSH);
  assign in_lookup = (state == S_LOOKUP);

  // Descending scan so the lowest matching way wins if duplicates ever exist.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (st_rd_valid[i] && (st_rd_vpn[i] == req_vpn)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(i);
      end
    end
  end

  tlb_victim_sel u_victim (
    .valid (snap_valid),
    .lru   (snap_lru),
    .way   (victim)
  );

  assign req_ready       = (state == S_IDLE) && !flush;
  assign flush_busy      = in_flush;
  assign ptw_req_valid   = (state == S_WALK_REQ);
  assign ptw_req_vpn     = req_vpn;
  assign st_rd_set_index = set_idx;

  assign st_wr_en        = (state == S_REFILL) || in_flush;
  assign st_wr_set_index = in_flush ? flush_idx[FLUSH_BITS-1:WAY_BITS] : set_idx;
  assign st_wr_way       = in_flush ? flush_idx[WAY_BITS-1:0] : victim;
  assign st_wr_valid     = (state == S_REFILL);
  assign st_wr_vpn       = in_flush ? '0 : req_vpn;
  assign st_wr_ppn       = in_flush ? '0 : walk_ppn;
  assign st_wr_perms     = in_flush ? '0 : walk_perms;
  assign st_wr_lru_count = in_flush ? '0 : LRU_MAX;

  // Aging decrements every live way except the one just used, from the lookup snapshot.
  assign age_dec = (state == S_AGE) && (age_idx != used_way) &&
                   snap_valid[age_idx] && (snap_lru[age_idx] != '0);

  assign st_lru_update_en = (in_lookup && hit) || age_dec;
  assign st_lru_set_index = set_idx;
  assign st_lru_way       = in_lookup ? hit_way : age_idx;
  assign st_lru_value     = in_lookup ? LRU_MAX : (snap_lru[age_idx] - LRU_BITS'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_vpn    <= '0;
      req_off    <= '0;
      req_wr     <= 1'b0;
      snap_valid <= '0;
      snap_lru   <= '0;
      used_way   <= '0;
      age_idx    <= '0;
      flush_idx  <= '0;
      walk_ppn   <= '0;
      walk_perms <= '0;
      resp_valid <= 1'b0;
      resp_paddr <= '0;
      resp_hit   <= 1'b0;
      resp_fault <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush) begin
            flush_idx <= '0;
            state     <= S_FLUSH;
          end else if (req_valid) begin
            req_vpn <= req_vaddr[31:12];
            req_off <= req_vaddr[11:0];
            req_wr  <= req_is_write;
            state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          snap_valid <= st_rd_valid;
          snap_lru   <= st_rd_lru_count;
          if (hit) begin
            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            used_way   <= hit_way;
            resp_valid <= 1'b1;
            resp_paddr <= {st_rd_ppn[hit_way], req_off};
            resp_hit   <= 1'b1;
            resp_fault <= perm_fault(req_wr, st_rd_perms[hit_way]);
            age_idx    <= '0;
            state      <= S_AGE;
          end else begin
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            state <= S_WALK_REQ;
          end
        end
        S_WALK_REQ: begin
          if (ptw_req_ready) state <= S_WALK_WAIT;
        end
        S_WALK_WAIT: begin
          if (ptw_resp_valid) begin
            if (ptw_resp_fault) begin
              resp_valid <= 1'b1;
              resp_paddr <= '0;
              resp_hit   <= 1'b0;
              resp_fault <= 1'b1;
              state      <= S_IDLE;
            end else begin
              walk_ppn   <= ptw_resp_ppn;
              walk_perms <= ptw_resp_perms;
              state      <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          used_way   <= victim;
          resp_valid <= 1'b1;
          resp_paddr <= {walk_ppn, req_off};
          resp_hit   <= 1'b0;
          resp_fault <= perm_fault(req_wr, walk_perms);
          age_idx    <= '0;
          state      <= S_AGE;
        end
        S_AGE: begin
          age_idx <= age_idx + WAY_BITS'(1);
          if (age_idx == WAY_BITS'(NUM_WAYS - 1)) state <= S_IDLE;
        end
        S_FLUSH: begin
          flush_idx <= flush_idx + FLUSH_BITS'(1);
          if (&flush_idx) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
